muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: EX-stage mult/multu/div/divu issue request.
REQ-004 SHALL have port op, input, 2 bits: operation select; 00 mult, 01 multu, 10 div, 11 divu.
REQ-005 SHALL have port a, input, 32 bits: rs operand (dividend or multiplicand).
REQ-006 SHALL have port b, input, 32 bits: rt operand (divisor or multiplier).
REQ-007 SHALL have port flush, input, 1 bit: pipeline flush; aborts any operation in progress.
REQ-008 SHALL have port hi_we, input, 1 bit: mthi write strobe.
REQ-009 SHALL have port lo_we, input, 1 bit: mtlo write strobe.
REQ-010 SHALL have port wdata, input, 32 bits: mthi/mtlo write data.
REQ-011 SHALL have port rd_hilo, input, 1 bit: ID stage holds mfhi/mflo.
REQ-012 SHALL have port busy, output, 1 bit: operation in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port stall, output, 1 bit: pipeline freeze request.
REQ-015 SHALL have port hi, output, 32 bits: HI register.
REQ-016 SHALL have port lo, output, 32 bits: LO register.

Function
REQ-017 SHALL implement states IDLE, MUL, DIV; 5-bit iteration counter.
REQ-018 SHALL, in IDLE, on start=1 and flush=0, latch op, a and b, load counter=0, and go to MUL (op 0x) or DIV (op 1x).
REQ-019 SHALL, for signed ops, operate on absolute values and fix signs at completion: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
REQ-020 SHALL perform one radix-2 step per cycle: shift-add for MUL, restoring subtract for DIV; exactly 32 steps.
REQ-021 SHALL, on the edge completing step 32, write HI and LO and return to IDLE: MUL gives HI=product[63:32], LO=product[31:0]; DIV gives LO=quotient, HI=remainder.
REQ-022 SHALL time an op as follows: start sampled at edge k; busy=1 in cycles k+1..k+32; done=1 only in cycle k+33; HI/LO new values visible in cycle k+33.
REQ-023 SHALL, for divide by zero (b=0, div or divu), still take 32 cycles and give LO=0xFFFFFFFF, HI=a.
REQ-024 SHALL, for div 0x80000000 / 0xFFFFFFFF, give LO=0x80000000, HI=0x00000000.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL, on flush=1 while busy, return to IDLE at that edge: busy=0 next cycle, HI/LO unchanged, no done pulse.
REQ-027 SHALL, on flush=1 and start=1 together in IDLE, not start (flush wins).
REQ-028 SHALL write wdata to HI on hi_we (LO on lo_we) only in IDLE; ignore both strobes while busy.
REQ-029 SHALL, on start and a write strobe together in IDLE, perform the write now; the later completion overwrites HI/LO.
REQ-030 SHALL drive stall = busy & (rd_hilo | start) combinationally.

Reset
REQ-031 SHALL, on rst_n=0 at a rising edge, enter IDLE and clear hi, lo, counter, busy and done to 0, including mid-operation; no done follows.
REQ-032 SHALL, after reset, drive stall=0 and ignore hi_we and lo_we while rst_n=0.

Verification
REQ-033 SHALL test mult: a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; done exactly 33 cycles after start edge; busy high 32 cycles.
REQ-034 SHALL test divu and div: divu 100/7 -> LO=14, HI=2; div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 SHALL test divide by zero: div a=5, b=0 -> LO=0xFFFFFFFF, HI=5 after 32 busy cycles; then 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-036 SHALL test flush: HI=0x11, LO=0x22; start multu 7*9; flush in busy cycle 10 -> busy=0 next cycle, no done, HI/LO still 0x11/0x22.
REQ-037 SHALL test stall and strobes: rd_hilo=1 during busy -> stall=1; rd_hilo=1 in IDLE -> stall=0; mthi 0xABCD during busy ignored; mthi in IDLE -> hi=0xABCD next cycle.
REQ-038 SHALL test reset mid-op: rst_n=0 at busy cycle 5 -> hi=lo=0, busy=0 next cycle; no done afterwards.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative 32x32 multiply / 32/32 divide unit with HI/LO
//               registers. It processes one radix-2 step per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        rd_hilo,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [63:0] r_prod;
    logic [31:0] r_opb;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_last;
    logic        w_launch;
    logic [32:0] w_mul_sum;
    logic [63:0] w_prod_nxt;
    logic [63:0] w_mul_res;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_quo_res;
    logic [31:0] w_rem_res;

    assign w_signed = ~op[0];
    assign w_a_mag  = (w_signed && a[31]) ? (32'd0 - a) : a;
    assign w_b_mag  = (w_signed && b[31]) ? (32'd0 - b) : b;
    assign w_last   = (r_cnt == 5'd31);
    assign w_launch = start && !flush;

    // Datapath for one step; on the last step the sign-corrected results are
    // taken straight from the step outputs so HI/LO land on the same edge.
    always_comb begin
        w_mul_sum   = r_prod[0] ? ({1'b0, r_prod[63:32]} + {1'b0, r_opb})
                                : {1'b0, r_prod[63:32]};
        w_prod_nxt  = {w_mul_sum, r_prod[31:1]};
        w_mul_res   = r_neg_q ? (64'd0 - w_prod_nxt) : w_prod_nxt;
        w_div_shift = {r_rem, r_quo[31]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_rem_nxt   = w_div_diff[32] ? w_div_shift[31:0] : w_div_diff[31:0];
        w_quo_nxt   = {r_quo[30:0], ~w_div_diff[32]};
        // A zero divisor must leave the all-ones quotient uncorrected.
        w_quo_res   = (r_neg_q && !r_div0) ? (32'd0 - w_quo_nxt) : w_quo_nxt;
        w_rem_res   = r_neg_r ? (32'd0 - w_rem_nxt) : w_rem_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_launch) begin
                    w_state_nxt = op[1] ? c_st_div : c_st_mul;
                end
            end
            c_st_mul, c_st_div: begin
                if (flush || w_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= 5'd0;
            r_prod  <= 64'd0;
            r_opb   <= 32'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (w_launch) begin
                        r_cnt   <= 5'd0;
                        r_prod  <= {32'd0, w_b_mag};
                        r_quo   <= w_a_mag;
                        r_rem   <= 32'd0;
                        r_opb   <= op[1] ? w_b_mag : w_a_mag;
                        r_neg_q <= w_signed && (a[31] ^ b[31]);
                        r_neg_r <= w_signed && a[31];
                        r_div0  <= (b == 32'd0);
                    end
                end
                c_st_mul: begin
                    if (!flush) begin
                        r_cnt  <= r_cnt + 5'd1;
                        r_prod <= w_prod_nxt;
                        if (w_last) begin
                            r_hi   <= w_mul_res[63:32];
                            r_lo   <= w_mul_res[31:0];
                            r_done <= 1'b1;
                        end
                    end
                end
                c_st_div: begin
                    if (!flush) begin
                        r_cnt <= r_cnt + 5'd1;
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (w_last) begin
                            r_hi   <= w_rem_res;
                            r_lo   <= w_quo_res;
                            r_done <= 1'b1;
                        end
                    end
                end
                default: r_cnt <= 5'd0;
            endcase
        end
    end

    assign busy  = (r_state != c_st_idle);
    assign done  = r_done;
    assign stall = busy && (rd_hilo || start);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire
